mem_shadow_ctrl: RTL and testbench

- Sequences host-side shadow accesses (read, write, dump, fill) to a DUT memory while emulation is frozen.
- Shares the memory's single synchronous port between the DUT and the host; the DUT owns the port whenever the block is idle or unfrozen.
- Sits in emu_top between the DUT memory instance and the host register/stream interface.

---
 rtl/mem_shadow_ctrl_if.sv | 61 ++++++
 rtl/mem_shadow_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_shadow_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_shadow_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_shadow_ctrl_if
// Host request/response channel of the shadow-memory controller.
//
// Signals:
//   host_req_valid_i  host request valid
//   host_req_ready_o  request accepted when valid & ready
//   host_req_op_i     op: 00 READ, 01 WRITE, 10 DUMP, 11 FILL
//   host_req_addr_i   start address
//   host_req_wdata_i  write/fill data
//   host_rsp_valid_o  response valid
//   host_rsp_ready_i  host accepts response
//   host_rsp_data_o   read data (echo of wdata for WRITE/FILL)
//   host_rsp_addr_o   address of the response word
//   host_rsp_last_o   final response of the op
//
// Modports:
//   slave  - the controller side
//   master - the host side
// ---------------------------------------------------------------------------
interface mem_shadow_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              host_req_valid_i;
    logic              host_req_ready_o;
    logic [1:0]        host_req_op_i;
    logic [ADDR_W-1:0] host_req_addr_i;
    logic [DATA_W-1:0] host_req_wdata_i;
    logic              host_rsp_valid_o;
    logic              host_rsp_ready_i;
    logic [DATA_W-1:0] host_rsp_data_o;
    logic [ADDR_W-1:0] host_rsp_addr_o;
    logic              host_rsp_last_o;

    modport slave (
        input  host_req_valid_i,
        input  host_req_op_i,
        input  host_req_addr_i,
        input  host_req_wdata_i,
        input  host_rsp_ready_i,
        output host_req_ready_o,
        output host_rsp_valid_o,
        output host_rsp_data_o,
        output host_rsp_addr_o,
        output host_rsp_last_o
    );

    modport master (
        output host_req_valid_i,
        output host_req_op_i,
        output host_req_addr_i,
        output host_req_wdata_i,
        output host_rsp_ready_i,
        input  host_req_ready_o,
        input  host_rsp_valid_o,
        input  host_rsp_data_o,
        input  host_rsp_addr_o,
        input  host_rsp_last_o
    );
endinterface

// File: rtl/mem_shadow_ctrl.sv
// ---------------------------------------------------------------------------
// mem_shadow_ctrl
// Sequences host shadow accesses (READ, WRITE, DUMP, FILL) to a DUT memory
// while emulation is frozen. The memory has a single synchronous port that
// is shared: the DUT owns it whenever the controller is idle, the controller
// owns it while an op is in flight.
//
// Ports:
//   clk_i        emulation clock
//   rst_ni       asynchronous active-low reset
//   freeze_i     DUT clock gated; host ops only allowed while high
//   dut_*_i      DUT-side memory request (we, addr, wdata)
//   host         host request/response channel (slave modport)
//   mem_*_o      memory port (we, addr, wdata)
//   mem_rdata_i  memory read data, one cycle after the address
//   busy_o       controller is not idle
//   abort_o      sticky: an op was aborted by freeze_i falling
//   ops_done_o   completed-op counter (wraps)
// ---------------------------------------------------------------------------
module mem_shadow_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              freeze_i,
    input  logic              dut_we_i,
    input  logic [ADDR_W-1:0] dut_addr_i,
    input  logic [DATA_W-1:0] dut_wdata_i,
    mem_shadow_ctrl_if.slave  host,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              abort_o,
    output logic [15:0]       ops_done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RSP,
        ST_WR,
        ST_FILL
    } state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_FILL  = 2'b11
    } op_e;

    // Extended by one bit so the range check also works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            r_state;
    op_e               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rspValid;
    logic [DATA_W-1:0] r_rspData;
    logic [ADDR_W-1:0] r_rspAddr;
    logic              r_rspLast;
    logic              r_abort;
    logic [15:0]       r_opsDone;

    logic w_idle;
    logic w_reqReady;
    logic w_reqFire;
    logic w_reqInRange;
    logic w_atLast;
    logic w_ctrlWe;

    // Ready is masked by rst_ni so a request cannot be accepted while the
    // controller is held in reset, even though the state already reads IDLE.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_reqReady   = w_idle & freeze_i & rst_ni;
    assign w_reqFire    = host.host_req_valid_i & w_reqReady;
    assign w_reqInRange = ({1'b0, host.host_req_addr_i} < DEPTH_EXT);
    assign w_atLast     = (r_addr == LAST_ADDR);
    assign w_ctrlWe     = (r_state == ST_WR) || (r_state == ST_FILL);

    // Port mux: the DUT drives the memory whenever the controller is idle,
    // which includes reset and the cycle right after an abort. Otherwise the
    // controller presents its working address; writes happen only in WR/FILL.
    assign mem_we_o    = w_idle ? dut_we_i    : w_ctrlWe;
    assign mem_addr_o  = w_idle ? dut_addr_i  : r_addr;
    assign mem_wdata_o = w_idle ? dut_wdata_i : r_wdata;

    assign host.host_req_ready_o = w_reqReady;
    assign host.host_rsp_valid_o = r_rspValid;
    assign host.host_rsp_data_o  = r_rspData;
    assign host.host_rsp_addr_o  = r_rspAddr;
    assign host.host_rsp_last_o  = r_rspLast;

    assign busy_o     = ~w_idle;
    assign abort_o    = r_abort;
    assign ops_done_o = r_opsDone;

    // Main sequencer. A falling freeze_i in any active state takes priority
    // over everything else, including a response handshake in the same
    // cycle: the op is dropped, abort is latched and the op is not counted.
    // READ and DUMP share the RD_ISSUE/RD_WAIT/RSP path; DUMP loops back to
    // RD_ISSUE after each non-final handshake. FILL walks the addresses one
    // per cycle and produces a single response at the end. Out-of-range
    // requests skip the memory and go straight to a single zero response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_READ;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspAddr  <= '0;
            r_rspLast  <= 1'b0;
            r_abort    <= 1'b0;
            r_opsDone  <= '0;
        end else if (!w_idle && !freeze_i) begin
            r_state    <= ST_IDLE;
            r_rspValid <= 1'b0;
            r_abort    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_reqFire) begin
                        r_op    <= op_e'(host.host_req_op_i);
                        r_addr  <= host.host_req_addr_i;
                        r_wdata <= host.host_req_wdata_i;
                        if (!w_reqInRange) begin
                            r_rspValid <= 1'b1;
                            r_rspData  <= '0;
                            r_rspAddr  <= host.host_req_addr_i;
                            r_rspLast  <= 1'b1;
                            r_state    <= ST_RSP;
                        end else begin
                            case (op_e'(host.host_req_op_i))
                                OP_READ:  r_state <= ST_RD_ISSUE;
                                OP_DUMP:  r_state <= ST_RD_ISSUE;
                                OP_WRITE: r_state <= ST_WR;
                                OP_FILL:  r_state <= ST_FILL;
                                default:  r_state <= ST_IDLE;
                            endcase
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_rspValid <= 1'b1;
                    r_rspData  <= mem_rdata_i;
                    r_rspAddr  <= r_addr;
                    r_rspLast  <= (r_op != OP_DUMP) || w_atLast;
                    r_state    <= ST_RSP;
                end
                ST_WR: begin
                    r_rspValid <= 1'b1;
                    r_rspData  <= r_wdata;
                    r_rspAddr  <= r_addr;
                    r_rspLast  <= 1'b1;
                    r_state    <= ST_RSP;
                end
                ST_FILL: begin
                    if (w_atLast) begin
                        r_rspValid <= 1'b1;
                        r_rspData  <= r_wdata;
                        r_rspAddr  <= LAST_ADDR;
                        r_rspLast  <= 1'b1;
                        r_state    <= ST_RSP;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                ST_RSP: begin
                    if (host.host_rsp_ready_i) begin
                        r_rspValid <= 1'b0;
                        if (r_rspLast) begin
                            r_state   <= ST_IDLE;
                            r_opsDone <= r_opsDone + 16'd1;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= ST_RD_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_shadow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_shadow_ctrl
// Self-checking bench for mem_shadow_ctrl. A behavioural synchronous memory
// sits on the mem_* port. Single-word host ops are run from a vector table;
// DUMP, FILL, abort and reset-in-flight are hand-written sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_shadow_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] expData;
        logic [3:0] expAddr;
        int         expLatency;
    } hostVec_t;

    logic              clk;
    logic              rstN;
    logic              freeze;
    logic              dutWe;
    logic [ADDR_W-1:0] dutAddr;
    logic [DATA_W-1:0] dutWdata;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              busy;
    logic              abortFlag;
    logic [15:0]       opsDone;

    logic [DATA_W-1:0] memArray [DEPTH];

    int checkCount = 0;
    int passCount  = 0;
    int opsModel   = 0;

    mem_shadow_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) hostIf ();

    mem_shadow_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .freeze_i    (freeze),
        .dut_we_i    (dutWe),
        .dut_addr_i  (dutAddr),
        .dut_wdata_i (dutWdata),
        .host        (hostIf),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .mem_rdata_i (memRdata),
        .busy_o      (busy),
        .abort_o     (abortFlag),
        .ops_done_o  (opsDone)
    );

    // 10 ns emulation clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port synchronous memory: read data appears one
    // cycle after the address.
    always @(posedge clk) begin
        if (memWe) memArray[memAddr] <= memWdata;
        memRdata <= memArray[memAddr];
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    // Present a host request and wait (bounded) until it is accepted.
    // Returns on the falling edge right after the accepting rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wdata);
        int n = 0;
        hostIf.host_req_valid_i = 1'b1;
        hostIf.host_req_op_i    = op;
        hostIf.host_req_addr_i  = addr;
        hostIf.host_req_wdata_i = wdata;
        #1;
        while (!hostIf.host_req_ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req accepted", {31'd0, hostIf.host_req_ready_o}, 32'd1);
        @(negedge clk);
        hostIf.host_req_valid_i = 1'b0;
    endtask

    // Wait (bounded) for a response, check it, optionally stall one cycle
    // with ready low, then complete the handshake.
    task automatic waitResponse(input string name, input logic [7:0] expData, input logic [3:0] expAddr,
                                input logic expLast, input bit stall, output int waited);
        waited = 0;
        while (!hostIf.host_rsp_valid_o && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, " valid"}, {31'd0, hostIf.host_rsp_valid_o}, 32'd1);
        checkOutput({name, " data"}, {24'd0, hostIf.host_rsp_data_o}, {24'd0, expData});
        checkOutput({name, " addr"}, {28'd0, hostIf.host_rsp_addr_o}, {28'd0, expAddr});
        checkOutput({name, " last"}, {31'd0, hostIf.host_rsp_last_o}, {31'd0, expLast});
        if (stall) begin
            @(negedge clk);
            checkOutput({name, " held valid"}, {31'd0, hostIf.host_rsp_valid_o}, 32'd1);
            checkOutput({name, " held data"}, {24'd0, hostIf.host_rsp_data_o}, {24'd0, expData});
        end
        hostIf.host_rsp_ready_i = 1'b1;
        @(negedge clk);
        hostIf.host_rsp_ready_i = 1'b0;
    endtask

    // One single-response host op with latency and counter checks.
    task automatic runVector(input hostVec_t v, input string tag);
        int waited;
        applyStimulus(v.op, v.addr, v.wdata);
        waitResponse(tag, v.expData, v.expAddr, 1'b1, 1'b0, waited);
        checkOutput({tag, " latency"}, waited, v.expLatency);
        opsModel++;
        checkOutput({tag, " ops_done"}, {16'd0, opsDone}, opsModel);
        checkOutput({tag, " ready after"}, {31'd0, hostIf.host_req_ready_o}, 32'd1);
    endtask

    hostVec_t vecs [10];

    initial begin
        int waited;
        int goodFill;

        // Latency counts falling edges after the one following the accept
        // edge: READ response appears 2 edges after accept, WRITE 1 edge.
        vecs[0] = '{OP_WRITE, 4'd5,  8'h3C, 8'h3C, 4'd5,  1};
        vecs[1] = '{OP_READ,  4'd5,  8'h00, 8'h3C, 4'd5,  2};
        vecs[2] = '{OP_READ,  4'd3,  8'h00, 8'h13, 4'd3,  2};
        vecs[3] = '{OP_WRITE, 4'd0,  8'hE1, 8'hE1, 4'd0,  1};
        vecs[4] = '{OP_READ,  4'd0,  8'h00, 8'hE1, 4'd0,  2};
        vecs[5] = '{OP_WRITE, 4'd15, 8'h42, 8'h42, 4'd15, 1};
        vecs[6] = '{OP_READ,  4'd15, 8'h00, 8'h42, 4'd15, 2};
        vecs[7] = '{OP_READ,  4'd14, 8'h00, 8'h1E, 4'd14, 2};
        vecs[8] = '{OP_WRITE, 4'd15, 8'h1F, 8'h1F, 4'd15, 1};
        vecs[9] = '{OP_READ,  4'd15, 8'h00, 8'h1F, 4'd15, 2};

        rstN     = 1'b0;
        freeze   = 1'b1;
        dutWe    = 1'b1;
        dutAddr  = 4'd9;
        dutWdata = 8'h5C;
        hostIf.host_req_valid_i = 1'b0;
        hostIf.host_req_op_i    = OP_READ;
        hostIf.host_req_addr_i  = '0;
        hostIf.host_req_wdata_i = '0;
        hostIf.host_rsp_ready_i = 1'b0;

        // Reset state.
        #3;
        checkOutput("reset ready", {31'd0, hostIf.host_req_ready_o}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset abort", {31'd0, abortFlag}, 32'd0);
        checkOutput("reset ops_done", {16'd0, opsDone}, 32'd0);
        checkOutput("reset rsp_valid", {31'd0, hostIf.host_rsp_valid_o}, 32'd0);
        checkOutput("reset rsp_data", {24'd0, hostIf.host_rsp_data_o}, 32'd0);
        checkOutput("reset rsp_last", {31'd0, hostIf.host_rsp_last_o}, 32'd0);
        checkOutput("reset mux addr", {28'd0, memAddr}, 32'd9);
        checkOutput("reset mux wdata", {24'd0, memWdata}, 32'h5C);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("post-reset ready", {31'd0, hostIf.host_req_ready_o}, 32'd1);
        dutWe = 1'b0;

        // Unfrozen: DUT owns the port, host request is ignored.
        @(negedge clk);
        freeze   = 1'b0;
        dutWe    = 1'b1;
        dutAddr  = 4'd3;
        dutWdata = 8'hA5;
        hostIf.host_req_valid_i = 1'b1;
        hostIf.host_req_op_i    = OP_READ;
        hostIf.host_req_addr_i  = 4'd2;
        #1;
        checkOutput("unfrozen mem_we", {31'd0, memWe}, 32'd1);
        checkOutput("unfrozen mem_addr", {28'd0, memAddr}, 32'd3);
        checkOutput("unfrozen mem_wdata", {24'd0, memWdata}, 32'hA5);
        checkOutput("unfrozen ready", {31'd0, hostIf.host_req_ready_o}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("unfrozen busy", {31'd0, busy}, 32'd0);
        checkOutput("unfrozen rsp_valid", {31'd0, hostIf.host_rsp_valid_o}, 32'd0);
        hostIf.host_req_valid_i = 1'b0;

        // Preload mem[i] = i + 0x10 through the DUT side of the mux.
        for (int i = 0; i < DEPTH; i++) begin
            dutAddr  = 4'(i);
            dutWdata = 8'(i + 16);
            @(negedge clk);
        end
        dutWe  = 1'b0;
        freeze = 1'b1;
        @(negedge clk);

        // Table of single-response ops.
        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // DUMP from 12 with one stall cycle per response.
        applyStimulus(OP_DUMP, 4'd12, 8'h00);
        checkOutput("dump12 busy", {31'd0, busy}, 32'd1);
        checkOutput("dump12 ready while busy", {31'd0, hostIf.host_req_ready_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            waitResponse($sformatf("dump12[%0d]", k), 8'(8'h1C + k), 4'(12 + k), (k == 3), 1'b1, waited);
        end
        opsModel++;
        checkOutput("dump12 idle", {31'd0, busy}, 32'd0);
        checkOutput("dump12 ops_done", {16'd0, opsDone}, opsModel);

        // FILL 0x77 from 0: 16 consecutive write cycles then one response.
        applyStimulus(OP_FILL, 4'd0, 8'h77);
        goodFill = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (memWe === 1'b1 && memAddr === 4'(i) && memWdata === 8'h77) goodFill++;
            @(negedge clk);
        end
        checkOutput("fill write cycles", goodFill, 32'd16);
        checkOutput("fill we after", {31'd0, memWe}, 32'd0);
        waitResponse("fill rsp", 8'h77, 4'd15, 1'b1, 1'b0, waited);
        opsModel++;
        checkOutput("fill ops_done", {16'd0, opsDone}, opsModel);

        // DUMP from 0 must now return 0x77 everywhere.
        applyStimulus(OP_DUMP, 4'd0, 8'h00);
        for (int k = 0; k < DEPTH; k++) begin
            waitResponse($sformatf("dump0[%0d]", k), 8'h77, 4'(k), (k == DEPTH - 1), 1'b0, waited);
        end
        opsModel++;
        checkOutput("dump0 ops_done", {16'd0, opsDone}, opsModel);

        // Abort: drop freeze after the third DUMP response.
        applyStimulus(OP_DUMP, 4'd0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            waitResponse($sformatf("abort dump[%0d]", k), 8'h77, 4'(k), 1'b0, 1'b0, waited);
        end
        checkOutput("abort pre busy", {31'd0, busy}, 32'd1);
        freeze = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort rsp_valid", {31'd0, hostIf.host_rsp_valid_o}, 32'd0);
        checkOutput("abort flag", {31'd0, abortFlag}, 32'd1);
        checkOutput("abort ops_done", {16'd0, opsDone}, opsModel);
        dutWe    = 1'b1;
        dutAddr  = 4'd7;
        dutWdata = 8'h12;
        #1;
        checkOutput("abort mux we", {31'd0, memWe}, 32'd1);
        checkOutput("abort mux addr", {28'd0, memAddr}, 32'd7);
        checkOutput("abort mux wdata", {24'd0, memWdata}, 32'h12);
        repeat (3) @(negedge clk);
        checkOutput("abort sticky", {31'd0, abortFlag}, 32'd1);
        dutWe = 1'b0;

        // Reset in the middle of a FILL: addresses 0 and 1 get written.
        freeze = 1'b1;
        @(negedge clk);
        applyStimulus(OP_FILL, 4'd0, 8'h55);
        @(negedge clk);
        @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midfill reset busy", {31'd0, busy}, 32'd0);
        checkOutput("midfill reset abort", {31'd0, abortFlag}, 32'd0);
        checkOutput("midfill reset ops_done", {16'd0, opsDone}, 32'd0);
        checkOutput("midfill reset ready", {31'd0, hostIf.host_req_ready_o}, 32'd0);
        checkOutput("midfill reset mem_we", {31'd0, memWe}, 32'd0);
        checkOutput("midfill reset rsp_valid", {31'd0, hostIf.host_rsp_valid_o}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        opsModel = 0;
        runVector('{OP_READ, 4'd0,  8'h00, 8'h55, 4'd0,  2}, "post-reset read0");
        runVector('{OP_READ, 4'd1,  8'h00, 8'h55, 4'd1,  2}, "post-reset read1");
        runVector('{OP_READ, 4'd10, 8'h00, 8'h77, 4'd10, 2}, "post-reset read10");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
